// File: rtl/ksa_sub16_pipe.sv
// Two-stage pipelined Kogge-Stone subtractor D = X - Y - Bin with valid/ready handshakes.
// Optional signed flags (V overflow, Z zero) are enabled by defining KSS_SIGNED_FLAGS_EN.
module ksa_sub16_pipe #(
    parameter int WIDTH = 16,
    parameter int SPLIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             Bout
`ifdef KSS_SIGNED_FLAGS_EN
    ,
    output logic             V,
    output logic             Z
`endif
);

    localparam int LEVELS = $clog2(WIDTH);

    // One Kogge-Stone level: bits at or above the span combine with the bit span below.
    function automatic logic [2*WIDTH-1:0] prefix_level(
        input logic [WIDTH-1:0] g_in,
        input logic [WIDTH-1:0] p_in,
        input int               span
    );
        logic [WIDTH-1:0] g_out;
        logic [WIDTH-1:0] p_out;
        int               j;
        g_out = g_in;
        p_out = p_in;
        for (int i = 0; i < WIDTH; i++) begin
            j = (i >= span) ? (i - span) : 0;
            if (i >= span) begin
                g_out[i] = g_in[i] | (p_in[i] & g_in[j]);
                p_out[i] = p_in[i] & p_in[j];
            end else begin
                g_out[i] = g_in[i];
                p_out[i] = p_in[i];
            end
        end
        return {g_out, p_out};
    endfunction

    logic             adv1_s, adv2_s;
    logic [WIDTH-1:0] p0_s, g1_s, p1_s;
    logic [WIDTH-1:0] g2_s, p2_s, carry_s, diff_s;
    logic             bout_s;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_p0_q, s1_p0_d;
    logic [WIDTH-1:0] s1_g_q, s1_g_d;
    logic [WIDTH-1:0] s1_p_q, s1_p_d;
    logic             s1_c_q, s1_c_d;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bout_q, bout_d;

`ifdef KSS_SIGNED_FLAGS_EN
    logic             s1_xmsb_q, s1_xmsb_d;
    logic             s1_ymsb_q, s1_ymsb_d;
    logic             v_q, v_d;
    logic             z_q, z_d;
    logic             v_s, z_s;
`endif

    // Handshake: a stage advances when it is empty or its successor advances.
    always_comb begin
        adv2_s = ~s2_valid_q | out_ready;
        adv1_s = ~s1_valid_q | adv2_s;
    end

    // Stage-1 arithmetic: per-bit generate/propagate and the first SPLIT prefix levels.
    always_comb begin
        p0_s = X ^ ~Y;
        g1_s = X & ~Y;
        p1_s = p0_s;
        for (int k = 1; k <= SPLIT; k++) begin
            {g1_s, p1_s} = prefix_level(g1_s, p1_s, 32'sd1 << (k - 1));
        end
    end

    // Stage-2 arithmetic: remaining prefix levels, then sum and borrow-out.
    always_comb begin
        g2_s = s1_g_q;
        p2_s = s1_p_q;
        for (int k = SPLIT + 1; k <= LEVELS; k++) begin
            {g2_s, p2_s} = prefix_level(g2_s, p2_s, 32'sd1 << (k - 1));
        end
        carry_s = {g2_s[WIDTH-2:0] | (p2_s[WIDTH-2:0] & {(WIDTH-1){s1_c_q}}), s1_c_q};
        diff_s  = s1_p0_q ^ carry_s;
        bout_s  = ~(g2_s[WIDTH-1] | (p2_s[WIDTH-1] & s1_c_q));
    end

`ifdef KSS_SIGNED_FLAGS_EN
    // Signed flags derived from the stage-2 result and the operand sign bits.
    always_comb begin
        v_s = (s1_xmsb_q ^ s1_ymsb_q) & (s1_xmsb_q ^ diff_s[WIDTH-1]);
        z_s = (diff_s == {WIDTH{1'b0}});
    end
`endif

    // Stage-1 next state: data loads only for an accepted beat.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_p0_d    = s1_p0_q;
        s1_g_d     = s1_g_q;
        s1_p_d     = s1_p_q;
        s1_c_d     = s1_c_q;
`ifdef KSS_SIGNED_FLAGS_EN
        s1_xmsb_d  = s1_xmsb_q;
        s1_ymsb_d  = s1_ymsb_q;
`endif
        if (adv1_s) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_p0_d   = p0_s;
                s1_g_d    = g1_s;
                s1_p_d    = p1_s;
                s1_c_d    = ~Bin;
`ifdef KSS_SIGNED_FLAGS_EN
                s1_xmsb_d = X[WIDTH-1];
                s1_ymsb_d = Y[WIDTH-1];
`endif
            end else begin
                s1_c_d = s1_c_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Stage-2 next state: results hold while stalled or when no beat arrives.
    always_comb begin
        s2_valid_d = s2_valid_q;
        d_d        = d_q;
        bout_d     = bout_q;
`ifdef KSS_SIGNED_FLAGS_EN
        v_d        = v_q;
        z_d        = z_q;
`endif
        if (adv2_s) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                d_d    = diff_s;
                bout_d = bout_s;
`ifdef KSS_SIGNED_FLAGS_EN
                v_d    = v_s;
                z_d    = z_s;
`endif
            end else begin
                bout_d = bout_q;
            end
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // Pipeline registers with synchronous reset that discards in-flight beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_p0_q    <= {WIDTH{1'b0}};
            s1_g_q     <= {WIDTH{1'b0}};
            s1_p_q     <= {WIDTH{1'b0}};
            s1_c_q     <= 1'b0;
            s2_valid_q <= 1'b0;
            d_q        <= {WIDTH{1'b0}};
            bout_q     <= 1'b0;
`ifdef KSS_SIGNED_FLAGS_EN
            s1_xmsb_q  <= 1'b0;
            s1_ymsb_q  <= 1'b0;
            v_q        <= 1'b0;
            z_q        <= 1'b0;
`endif
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_p0_q    <= s1_p0_d;
            s1_g_q     <= s1_g_d;
            s1_p_q     <= s1_p_d;
            s1_c_q     <= s1_c_d;
            s2_valid_q <= s2_valid_d;
            d_q        <= d_d;
            bout_q     <= bout_d;
`ifdef KSS_SIGNED_FLAGS_EN
            s1_xmsb_q  <= s1_xmsb_d;
            s1_ymsb_q  <= s1_ymsb_d;
            v_q        <= v_d;
            z_q        <= z_d;
`endif
        end
    end

    assign in_ready  = adv1_s;
    assign out_valid = s2_valid_q;
    assign D         = d_q;
    assign Bout      = bout_q;
`ifdef KSS_SIGNED_FLAGS_EN
    assign V         = v_q;
    assign Z         = z_q;
`endif

endmodule

// File: tb/tb_ksa_sub16_pipe.sv
// Directed and streaming bench for ksa_sub16_pipe (default build, no signed flags).
module tb_ksa_sub16_pipe;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic        bin;
        logic [15:0] d;
        logic        bout;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] X, Y;
    logic        Bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] D;
    logic        Bout;

    int          n_cmp  = 0;
    int          n_fail = 0;
    int          cyc    = 0;

    logic [15:0] got_d[$];
    logic        got_b[$];
    int          got_c[$];
    logic [15:0] exp_d[$];
    logic        exp_b[$];

    vec_t        tbl[13];

    ksa_sub16_pipe dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .X        (X),
        .Y        (Y),
        .Bin      (Bin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .D        (D),
        .Bout     (Bout)
    );

    always #5 clk = ~clk;

    // Cycle counter used to detect bubbles between transfers.
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            got_d.push_back(D);
            got_b.push_back(Bout);
            got_c.push_back(cyc);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Single beat into an empty pipeline: verifies 2-cycle latency and the result.
    task automatic send_one(input vec_t v, input int idx);
        out_ready = 1'b1;
        X = v.x; Y = v.y; Bin = v.bin; in_valid = 1'b1;
        check($sformatf("vec%0d_in_ready", idx), {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check($sformatf("vec%0d_lat1_valid", idx), {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        check($sformatf("vec%0d_valid", idx), {31'd0, out_valid}, 32'd1);
        check($sformatf("vec%0d_D", idx), {16'd0, D}, {16'd0, v.d});
        check($sformatf("vec%0d_Bout", idx), {31'd0, Bout}, {31'd0, v.bout});
        @(posedge clk); #1;
    endtask

    task automatic set_beat(input int k, input bit rnd);
        if (rnd) begin
            X   = 16'($urandom);
            Y   = 16'($urandom);
            Bin = 1'($urandom);
        end else begin
            X   = 16'(k + 1);
            Y   = 16'd0;
            Bin = 1'b0;
        end
    endtask

    // Streams n beats; out_ready is held low for the first `stall` cycles.
    task automatic stream(input int n, input int stall, input bit rnd);
        int          sent   = 0;
        int          budget = 0;
        int          bubbles = 0;
        bit          acc;
        logic [16:0] r;
        got_d.delete(); got_b.delete(); got_c.delete();
        exp_d.delete(); exp_b.delete();
        out_ready = (stall == 0);
        set_beat(0, rnd);
        in_valid = 1'b1;
        while (sent < n && budget < 5000) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            budget++;
            if (acc) begin
                r = {1'b0, X} - {1'b0, Y} - {16'd0, Bin};
                exp_d.push_back(r[15:0]);
                exp_b.push_back(r[16]);
                sent++;
                if (sent < n) set_beat(sent, rnd);
                else in_valid = 1'b0;
            end
            if (stall > 0 && budget == stall) begin
                check("bp_accepted", sent, 32'd2);
                check("bp_in_ready", {31'd0, in_ready}, 32'd0);
                check("bp_out_valid", {31'd0, out_valid}, 32'd1);
                check("bp_D_held", {16'd0, D}, 32'd1);
                out_ready = 1'b1;
            end
        end
        if (budget >= 5000) check("stream_timeout", budget, 32'd0);
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("stream_count", got_d.size(), n);
        for (int k = 0; k < got_d.size() && k < exp_d.size(); k++) begin
            check($sformatf("stream_D%0d", k), {16'd0, got_d[k]}, {16'd0, exp_d[k]});
            check($sformatf("stream_B%0d", k), {31'd0, got_b[k]}, {31'd0, exp_b[k]});
            if (k > 0 && got_c[k] - got_c[k-1] != 1) bubbles++;
        end
        check("stream_bubbles", bubbles, 32'd0);
    endtask

    initial begin
        tbl[0]  = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0};
        tbl[1]  = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1};
        tbl[2]  = '{16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0};
        tbl[3]  = '{16'h8000, 16'h0000, 1'b1, 16'h7FFF, 1'b0};
        tbl[4]  = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1};
        tbl[5]  = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
        tbl[6]  = '{16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1};
        tbl[7]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        tbl[8]  = '{16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0};
        tbl[9]  = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1};
        tbl[10] = '{16'hAAAA, 16'h5555, 1'b0, 16'h5555, 1'b0};
        tbl[11] = '{16'h1000, 16'h0001, 1'b1, 16'h0FFE, 1'b0};
        tbl[12] = '{16'h5555, 16'hAAAA, 1'b0, 16'hAAAB, 1'b1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        X = 16'd0; Y = 16'd0; Bin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_D", {16'd0, D}, 32'd0);
        check("rst_Bout", {31'd0, Bout}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) send_one(tbl[i], i);

        stream(4, 4, 1'b0);
        stream(1000, 0, 1'b1);

        // Reset with two beats in flight and the output stalled.
        got_d.delete(); got_b.delete(); got_c.delete();
        out_ready = 1'b0;
        X = 16'h0009; Y = 16'h0001; Bin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        X = 16'h000A;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("mid_pre_valid", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_in_ready", {31'd0, in_ready}, 32'd1);
        check("mid_D", {16'd0, D}, 32'd0);
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("mid_no_stale", got_d.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ksa_sub16_pipe.md
Name: ksa_sub16_pipe

Overview:
- Pipelined 16-bit unsigned subtractor built on a Kogge-Stone prefix network: D = X - Y - Bin, implemented as X + ~Y + ~Bin.
- The inverse-operation companion to the combinational 16-bit Kogge-Stone adder in the circuits library.
- Two register stages with valid/ready handshakes at input and output, so it can sit in streaming datapaths and approximate-logic-synthesis benchmarks that need sequential timing.

Parameters:
- WIDTH, 16, operand width; the prefix tree has ceil(log2(WIDTH)) levels. Only 16 is verified.
- SPLIT, 2, number of prefix levels computed before the stage-1 register; the remaining levels are computed in stage 2.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept an operand beat
- X  input  WIDTH  minuend
- Y  input  WIDTH  subtrahend
- Bin  input  1  borrow-in, for chaining
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts the result
- D  output  WIDTH  difference X - Y - Bin, modulo 2^WIDTH
- Bout  output  1  borrow-out; 1 iff X < Y + Bin (unsigned)

Behaviour:
- Reset (rst=1 at a clock edge):
  - s1_valid=0, s2_valid=0, out_valid=0, D=0, Bout=0.
  - in_ready=1 in the cycle after reset.
  - In-flight beats are discarded. A reset mid-operation drops them, with no output.
- Arithmetic:
  - Per bit: g0 = X & ~Y, p0 = X ^ ~Y; carry-in c = ~Bin.
  - Carry operator: (G, P) = (Gh | (Ph & Gl), Ph & Pl).
  - Level k uses span 2^(k-1). Bits below the span pass through unchanged.
  - D[i] = p0[i] ^ (G[i-1] | (P[i-1] & c)), with D[0] = p0[0] ^ c.
  - Bout = ~(G[WIDTH-1] | (P[WIDTH-1] & c)).
- Stage 1 (registered):
  - p0 vector, plus G/P after SPLIT prefix levels, plus c.
  - With the defaults this is levels 1-2 (spans 1, 2).
- Stage 2 (registered):
  - Completes the remaining levels (spans 4, 8) and forms D and Bout into the output registers.
- Latency: exactly 2 cycles from input acceptance to out_valid, when not stalled.
- Throughput: 1 beat per cycle.
- Handshake:
  - Input is accepted when in_valid & in_ready.
  - Output is transferred when out_valid & out_ready.
  - adv2 = ~s2_valid | out_ready.
  - adv1 = ~s1_valid | adv2.
  - in_ready = adv1, combinational from out_ready and state. There is no combinational path from in_valid to in_ready.
  - Stage registers load only when their advance signal is high. Otherwise they hold their value.
  - While out_valid=1 and out_ready=0, D, Bout and out_valid are stable.
- Full / empty conditions:
  - Both stages full and out_ready=0 → in_ready=0.
  - Simultaneous accept and transfer in the same cycle sustains full rate with no bubble.
  - Empty pipeline → out_valid=0. D/Bout keep their last value and are don't-care.
- Ordering: results leave strictly in acceptance order. No beat is dropped or duplicated.
- Boundary values:
  - 0 - 0 - 0 gives D=0, Bout=0.
  - 0 - 0xFFFF - 1 gives D=0, Bout=1.
  - Wrap-around is modulo 2^WIDTH.

Optional Feature:
- Macro: KSS_SIGNED_FLAGS_EN
- Defined:
  - Adds outputs V (1 bit, two's-complement overflow) and Z (1 bit, D==0). Both are registered in stage 2 alongside D.
  - V = (X[MSB] ^ Y[MSB]) & (X[MSB] ^ D[MSB]).
  - Both reset to 0 and follow the same hold and stall rules as D.
- Undefined:
  - Ports V and Z are absent. No extra logic is generated.

Test Plan:
- Basic: X=0x0005, Y=0x0003, Bin=0, out_ready=1 → 2 cycles later D=0x0002, Bout=0 (V=0, Z=0).
- Underflow: X=0x0000, Y=0x0001, Bin=0 → D=0xFFFF, Bout=1. Then X=0x1234, Y=0x1234, Bin=0 → D=0x0000, Bout=0 (Z=1).
- Borrow-in and signed overflow: X=0x8000, Y=0x0000, Bin=1 → D=0x7FFF, Bout=0 (V=1). Then X=0x7FFF, Y=0xFFFF, Bin=0 → D=0x8000, Bout=1 (V=1).
- Backpressure:
  - Stimulus: stream 4 beats (X=1..4, Y=0) with out_ready=0 for 4 cycles.
  - Required while stalled: in_ready falls after 2 beats are accepted; D=1 is held.
  - Required on release: after out_ready=1, D=1, 2, 3, 4 emerge in consecutive cycles. None lost.
- Full-rate streaming: 1000 random beats with in_valid=1 and out_ready=1 → one result per cycle matching reference X-Y-Bin, with zero bubbles after fill.
- Reset mid-operation: accept 2 beats, then assert rst for 1 cycle → out_valid=0 on the next cycle, no stale results appear, and in_ready=1.
